cache_mem_responder: RTL and testbench



---
 rtl/cache_mem_responder.sv | 134 +++++++++++++
 tb/tb_cache_mem_responder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: fixed-latency main memory model behind the cache FSM.
// In: clk, reset, MStrobe, MRW, MAddr, MDataW. Out: MDataR, MRdy, MBusy.
module cache_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4,
  parameter int BURST   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataW,
  output logic [DATA_W-1:0] MDataR,
  output logic              MRdy,
  output logic              MBusy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  // WAIT spans LATENCY-1 cycles; the counter runs down to zero.
  localparam logic [CW-1:0] CNT_INIT =
    CW'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [IW-1:0] LINE_MASK = ~IW'(BURST - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WACK
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              rw_q, rw_d;
  logic [IW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [BW-1:0]     beat_nxt;
  logic [IW-1:0]     rd_idx;
  logic              we;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    beat_nxt = '0;
    we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MStrobe) begin
          rw_d    = MRW;
          addr_d  = MAddr[IW-1:0];
          wdata_d = MDataW;
          cnt_d   = CNT_INIT;
          beat_d  = '0;
          if (LATENCY > 1) state_d = S_WAIT;
          else state_d = MRW ? S_RBURST : S_WACK;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = rw_q ? S_RBURST : S_WACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RBURST: begin
        beat_nxt = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_WACK: begin
        we      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Data for the beat shown next cycle is fetched at the edge entering it.
  assign rd_idx = (addr_d & LINE_MASK) | IW'(beat_nxt);

  always_comb begin
    rdata_d = rdata_q;
    if (state_d == S_RBURST) rdata_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Backing array is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (we && !reset) mem_q[addr_q] <= wdata_q;
  end

  assign MRdy   = (state_q == S_RBURST) || (state_q == S_WACK);
  assign MBusy  = (state_q != S_IDLE);
  assign MDataR = rdata_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: randomized self-checking bench for cache_mem_responder.
// Reference: word array plus per-cycle expectations derived from latency/burst rules.
module tb_cache_mem_responder;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int D  = 256;
  localparam int L  = 4;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          MStrobe;
  logic          MRW;
  logic [AW-1:0] MAddr;
  logic [DW-1:0] MDataW;
  logic [DW-1:0] MDataR;
  logic          MRdy;
  logic          MBusy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mm [D];

  logic          rdy_log  [32];
  logic          busy_log [32];
  logic [DW-1:0] data_log [32];

  logic          exp_rdy  [32];
  logic          exp_busy [32];
  logic          exp_rd   [32];
  logic [DW-1:0] exp_data [32];
  int            exp_n;

  always #5 clk = ~clk;

  cache_mem_responder #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (D),
    .LATENCY(L),
    .BURST  (B)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .MStrobe(MStrobe),
    .MRW    (MRW),
    .MAddr  (MAddr),
    .MDataW (MDataW),
    .MDataR (MDataR),
    .MRdy   (MRdy),
    .MBusy  (MBusy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Cycle k = k-th cycle after the acceptance edge.
  function automatic void model_txn(input logic rw,
                                    input logic [AW-1:0] a,
                                    input logic [DW-1:0] d);
    int base;
    base  = int'(a) - (int'(a) % B);
    exp_n = rw ? L + B : L + 1;
    for (int k = 1; k <= exp_n; k++) begin
      exp_busy[k] = (k < exp_n);
      exp_rdy[k]  = (k >= L) && (k < exp_n);
      exp_rd[k]   = rw && exp_rdy[k];
      exp_data[k] = exp_rd[k] ? mm[(base + k - L) % D] : '0;
    end
    if (!rw) mm[int'(a) % D] = d;
  endfunction

  task automatic capture(input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int n);
    MStrobe = 1'b1;
    MRW     = rw;
    MAddr   = a;
    MDataW  = d;
    @(posedge clk); #1;
    MStrobe = 1'b0;
    MRW     = 1'($urandom);
    MAddr   = AW'($urandom);
    MDataW  = $urandom;
    for (int k = 1; k <= n; k++) begin
      rdy_log[k]  = MRdy;
      busy_log[k] = MBusy;
      data_log[k] = MDataR;
      if (k < n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    logic [DW-1:0] v;
    v = 32'h1234_5678;
    reset = 1'b1;
    MStrobe = 1'b1;
    MRW = 1'b0;
    MAddr = '0;
    MDataW = v;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (MRdy !== 1'b0) begin
        errors++;
        $display("FAIL reset_rdy cyc%0d got %b exp 0", i, MRdy);
      end
      checks++;
      if (MBusy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy cyc%0d got %b exp 0", i, MBusy);
      end
      checks++;
      if (MDataR !== '0) begin
        errors++;
        $display("FAIL reset_data cyc%0d got %h exp 0", i, MDataR);
      end
    end
    reset = 1'b0;
    model_txn(1'b0, '0, v);
    capture(1'b0, '0, v, exp_n);
    for (int k = 1; k <= exp_n; k++) begin
      checks++;
      if (busy_log[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL first_accept_busy cyc%0d got %b exp %b",
                 k, busy_log[k], exp_busy[k]);
      end
      checks++;
      if (rdy_log[k] !== exp_rdy[k]) begin
        errors++;
        $display("FAIL first_accept_rdy cyc%0d got %b exp %b",
                 k, rdy_log[k], exp_rdy[k]);
      end
    end
  endtask

  task automatic test_init;
    logic [DW-1:0] v;
    for (int a = 0; a < D; a++) begin
      v = $urandom;
      model_txn(1'b0, AW'(a), v);
      capture(1'b0, AW'(a), v, exp_n);
    end
  endtask

  task automatic test_write_readback;
    model_txn(1'b0, 16'h0011, 32'hDEAD_BEEF);
    capture(1'b0, 16'h0011, 32'hDEAD_BEEF, exp_n);
    for (int k = 1; k <= exp_n; k++) begin
      checks++;
      if (rdy_log[k] !== exp_rdy[k]) begin
        errors++;
        $display("FAIL wr_rdy cyc%0d got %b exp %b", k, rdy_log[k], exp_rdy[k]);
      end
      checks++;
      if (busy_log[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL wr_busy cyc%0d got %b exp %b", k, busy_log[k], exp_busy[k]);
      end
    end
    model_txn(1'b1, 16'h0010, '0);
    capture(1'b1, 16'h0010, '0, exp_n);
    for (int k = 1; k <= exp_n; k++) begin
      checks++;
      if (rdy_log[k] !== exp_rdy[k]) begin
        errors++;
        $display("FAIL rb_rdy cyc%0d got %b exp %b", k, rdy_log[k], exp_rdy[k]);
      end
      if (exp_rd[k]) begin
        checks++;
        if (data_log[k] !== exp_data[k]) begin
          errors++;
          $display("FAIL rb_data cyc%0d got %h exp %h", k, data_log[k], exp_data[k]);
        end
      end
    end
    checks++;
    if (data_log[L + 1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rb_beat1 got %h exp deadbeef", data_log[L + 1]);
    end
  endtask

  task automatic test_burst;
    for (int i = 0; i < 4; i++) begin
      model_txn(1'b0, AW'(32 + i), DW'(32'hA0 + i));
      capture(1'b0, AW'(32 + i), DW'(32'hA0 + i), exp_n);
    end
    model_txn(1'b1, 16'h0022, '0);
    capture(1'b1, 16'h0022, '0, exp_n);
    for (int k = 1; k <= exp_n; k++) begin
      checks++;
      if (rdy_log[k] !== exp_rdy[k]) begin
        errors++;
        $display("FAIL burst_rdy cyc%0d got %b exp %b", k, rdy_log[k], exp_rdy[k]);
      end
      checks++;
      if (busy_log[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL burst_busy cyc%0d got %b exp %b", k, busy_log[k], exp_busy[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_log[L + i] !== DW'(32'hA0 + i)) begin
        errors++;
        $display("FAIL burst_beat%0d got %h exp %h", i, data_log[L + i], 32'hA0 + i);
      end
    end
  endtask

  task automatic test_strobe_held;
    logic [DW-1:0] v;
    v = $urandom;
    model_txn(1'b1, 16'h0020, '0);
    MStrobe = 1'b1;
    MRW = 1'b1;
    MAddr = 16'h0020;
    MDataW = '0;
    @(posedge clk); #1;
    MAddr = 16'h0040;
    MRW = 1'b0;
    MDataW = v;
    for (int k = 1; k <= exp_n; k++) begin
      checks++;
      if (MRdy !== exp_rdy[k]) begin
        errors++;
        $display("FAIL held_rd_rdy cyc%0d got %b exp %b", k, MRdy, exp_rdy[k]);
      end
      checks++;
      if (MBusy !== exp_busy[k]) begin
        errors++;
        $display("FAIL held_rd_busy cyc%0d got %b exp %b", k, MBusy, exp_busy[k]);
      end
      if (exp_rd[k]) begin
        checks++;
        if (MDataR !== exp_data[k]) begin
          errors++;
          $display("FAIL held_rd_data cyc%0d got %h exp %h", k, MDataR, exp_data[k]);
        end
      end
      if (k < exp_n) begin
        @(posedge clk); #1;
      end
    end
    model_txn(1'b0, 16'h0040, v);
    @(posedge clk); #1;
    MStrobe = 1'b0;
    for (int k = 1; k <= exp_n; k++) begin
      checks++;
      if (MRdy !== exp_rdy[k]) begin
        errors++;
        $display("FAIL held_wr_rdy cyc%0d got %b exp %b", k, MRdy, exp_rdy[k]);
      end
      checks++;
      if (MBusy !== exp_busy[k]) begin
        errors++;
        $display("FAIL held_wr_busy cyc%0d got %b exp %b", k, MBusy, exp_busy[k]);
      end
      if (k < exp_n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] v;
    v = $urandom;
    model_txn(1'b0, 16'h01FF, v);
    capture(1'b0, 16'h01FF, v, exp_n);
    model_txn(1'b1, 16'h00FC, '0);
    capture(1'b1, 16'h00FC, '0, exp_n);
    for (int k = 1; k <= exp_n; k++) begin
      if (exp_rd[k]) begin
        checks++;
        if (data_log[k] !== exp_data[k]) begin
          errors++;
          $display("FAIL wrap_data cyc%0d got %h exp %h", k, data_log[k], exp_data[k]);
        end
      end
    end
    checks++;
    if (data_log[L + 3] !== v) begin
      errors++;
      $display("FAIL wrap_beat3 got %h exp %h", data_log[L + 3], v);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] old;
    MStrobe = 1'b1;
    MRW = 1'b1;
    MAddr = 16'h0020;
    @(posedge clk); #1;
    MStrobe = 1'b0;
    repeat (L + 1) begin
      @(posedge clk); #1;
    end
    checks++;
    if (MRdy !== 1'b1 || MDataR !== mm[16'h22]) begin
      errors++;
      $display("FAIL rst_beat2 got rdy=%b data=%h exp rdy=1 data=%h",
               MRdy, MDataR, mm[16'h22]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (MRdy !== 1'b0 || MBusy !== 1'b0 || MDataR !== '0) begin
      errors++;
      $display("FAIL rst_abort got rdy=%b busy=%b data=%h exp 0 0 0",
               MRdy, MBusy, MDataR);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (MRdy !== 1'b0) begin
        errors++;
        $display("FAIL rst_nobeat cyc%0d got %b exp 0", i, MRdy);
      end
    end
    old = mm[16'h30];
    MStrobe = 1'b1;
    MRW = 1'b0;
    MAddr = 16'h0030;
    MDataW = ~old;
    @(posedge clk); #1;
    MStrobe = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (MBusy !== 1'b1 || MRdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait got busy=%b rdy=%b exp 1 0", MBusy, MRdy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (MBusy !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_busy got %b exp 0", MBusy);
    end
    model_txn(1'b1, 16'h0030, '0);
    capture(1'b1, 16'h0030, '0, exp_n);
    checks++;
    if (data_log[L] !== old) begin
      errors++;
      $display("FAIL rst_wr_old got %h exp %h", data_log[L], old);
    end
  endtask

  task automatic test_random;
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int t = 0; t < 60; t++) begin
      rw = 1'($urandom);
      a  = AW'($urandom);
      d  = $urandom;
      model_txn(rw, a, d);
      capture(rw, a, d, exp_n);
      for (int k = 1; k <= exp_n; k++) begin
        checks++;
        if (rdy_log[k] !== exp_rdy[k]) begin
          errors++;
          $display("FAIL rnd_rdy t%0d cyc%0d got %b exp %b", t, k, rdy_log[k], exp_rdy[k]);
        end
        checks++;
        if (busy_log[k] !== exp_busy[k]) begin
          errors++;
          $display("FAIL rnd_busy t%0d cyc%0d got %b exp %b", t, k, busy_log[k], exp_busy[k]);
        end
        if (exp_rd[k]) begin
          checks++;
          if (data_log[k] !== exp_data[k]) begin
            errors++;
            $display("FAIL rnd_data t%0d cyc%0d got %h exp %h", t, k, data_log[k], exp_data[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_write_readback;
    test_burst;
    test_strobe_held;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
